// File: rtl/riscv_pkg.sv
// Shared RV32I register-file constants and types.
package riscv_pkg;

    localparam int XLEN       = 32;
    localparam int NREGS      = 32;
    localparam int REG_ADDR_W = 5;

    typedef enum logic {
        RF_CLEAR = 1'b0,
        RF_RUN   = 1'b1
    } rf_state_t;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_rd_port.sv
// Combinational register-file read port: x0 and CLEAR force to zero.
// Optional write-through forwarding when WB_REGFILE_BYPASS_EN is defined.
module wb_regfile_rd_port
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN
) (
    input  logic                  run,
    input  logic [REG_ADDR_W-1:0] rs_addr,
    input  logic [XLEN-1:0]       arr_data,
`ifdef WB_REGFILE_BYPASS_EN
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
`endif
    output logic [XLEN-1:0]       rs_data
);

    always_comb begin
        rs_data = '0;
        if (run && (rs_addr != REG_ZERO)) begin
            rs_data = arr_data;
`ifdef WB_REGFILE_BYPASS_EN
            if (wb_en && (wb_addr == rs_addr))
                rs_data = wb_data;
`endif
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// RV32I architectural register file with post-reset clear sequencer.
// Build option: WB_REGFILE_BYPASS_EN enables write-back to read forwarding.
module wb_regfile
    import riscv_pkg::*;
#(
    parameter int XLEN  = riscv_pkg::XLEN,
    parameter int NREGS = riscv_pkg::NREGS
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wb_en,
    input  logic [REG_ADDR_W-1:0] wb_addr,
    input  logic [XLEN-1:0]       wb_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    output logic [XLEN-1:0]       rs1_data,
    output logic [XLEN-1:0]       rs2_data,
    output logic                  ready,
    output logic [31:0]           wr_count
);

    localparam int AW = $clog2(NREGS);

    logic [XLEN-1:0] regs [NREGS];
    rf_state_t       state;
    logic [AW-1:0]   clr_idx;
    logic            run;
    logic            wb_we;

    assign run   = (state == RF_RUN);
    assign wb_we = run && wb_en && (wb_addr != REG_ZERO);

    // Array has no reset; the CLEAR sequence zeroes it one entry per cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= RF_CLEAR;
            clr_idx  <= '0;
            ready    <= 1'b0;
            wr_count <= '0;
        end else begin
            case (state)
                RF_CLEAR: begin
                    regs[clr_idx] <= '0;
                    clr_idx       <= clr_idx + 1'b1;
                    if (clr_idx == AW'(NREGS - 1)) begin
                        state <= RF_RUN;
                        ready <= 1'b1;
                    end
                end
                RF_RUN: begin
                    if (wb_we) begin
                        regs[wb_addr[AW-1:0]] <= wb_data;
                        wr_count              <= wr_count + 32'd1;
                    end
                end
                default: state <= RF_CLEAR;
            endcase
        end
    end

    wb_regfile_rd_port #(.XLEN(XLEN)) u_rd1 (
        .run      (run),
        .rs_addr  (rs1_addr),
        .arr_data (regs[rs1_addr[AW-1:0]]),
`ifdef WB_REGFILE_BYPASS_EN
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
`endif
        .rs_data  (rs1_data)
    );

    wb_regfile_rd_port #(.XLEN(XLEN)) u_rd2 (
        .run      (run),
        .rs_addr  (rs2_addr),
        .arr_data (regs[rs2_addr[AW-1:0]]),
`ifdef WB_REGFILE_BYPASS_EN
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
`endif
        .rs_data  (rs2_data)
    );

endmodule

// File: tb/tb_wb_regfile.sv
// Scoreboard bench for wb_regfile against a behavioural register-file model.
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic        ready;
    logic [31:0] wr_count;

    always #5 clk = ~clk;

    wb_regfile #(.XLEN(32), .NREGS(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .wb_en    (wb_en),
        .wb_addr  (wb_addr),
        .wb_data  (wb_data),
        .rs1_addr (rs1_addr),
        .rs2_addr (rs2_addr),
        .rs1_data (rs1_data),
        .rs2_data (rs2_data),
        .ready    (ready),
        .wr_count (wr_count)
    );

    typedef struct {
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic        rdy;
        logic [31:0] cnt;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: architectural contents, a countdown of entries left
    // to clear, and a count of committed writes.
    logic [31:0] mem [32];
    int          clear_left;
    logic [31:0] cnt;
    bit          known;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        while (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            check("rs1_data", rs1_data, e.rs1);
            check("rs2_data", rs2_data, e.rs2);
            check("ready", {31'd0, ready}, {31'd0, e.rdy});
            check("wr_count", wr_count, e.cnt);
        end
    end

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic en,
                                               input logic [4:0] wa, input logic [31:0] wd);
        if (clear_left != 0 || a == 5'd0) return 32'd0;
`ifdef WB_REGFILE_BYPASS_EN
        if (en && wa == a) return wd;
`endif
        return mem[a];
    endfunction

    task automatic cycle(input logic rn, input logic en, input logic [4:0] wa,
                         input logic [31:0] wd, input logic [4:0] a1, input logic [4:0] a2);
        exp_t e;
        rst_n = rn; wb_en = en; wb_addr = wa; wb_data = wd;
        rs1_addr = a1; rs2_addr = a2;
        if (known) begin
            e.rs1 = model_read(a1, en, wa, wd);
            e.rs2 = model_read(a2, en, wa, wd);
            e.rdy = (clear_left == 0);
            e.cnt = cnt;
            sb.push_back(e);
        end
        @(posedge clk);
        if (!rn) begin
            clear_left = 32;
            cnt        = 32'd0;
            known      = 1'b1;
        end else if (known) begin
            if (clear_left != 0) begin
                mem[32 - clear_left] = 32'd0;
                clear_left--;
            end else if (en && wa != 5'd0) begin
                mem[wa] = wd;
                cnt     = cnt + 32'd1;
            end
        end
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            cycle(1'b1, 1'b0, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));
    endtask

    initial begin
        logic [4:0] wa, a1, a2;
        logic       en;
        known = 1'b0;
        clear_left = 32;
        cnt = 32'd0;
        for (int i = 0; i < 32; i++) mem[i] = 32'd0;
        #1;

        // Reset then clear, with a dropped write at clear cycle 10
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd1, 5'd2);
        idle(10);
        cycle(1'b1, 1'b1, 5'd3, 32'h0000ABCD, 5'd3, 5'd3);
        idle(24);
        for (int i = 0; i < 16; i++)
            cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'(2 * i), 5'(2 * i + 1));

        // Directed write/read, x0 protection, same-cycle read of a write
        cycle(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd5, 5'd5);
        cycle(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd0, 5'd5);
        cycle(1'b1, 1'b1, 5'd7, 32'h11111111, 5'd1, 5'd2);
        cycle(1'b1, 1'b1, 5'd7, 32'h22222222, 5'd5, 5'd7);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd7, 5'd7);

        // Randomized traffic, biased toward address collisions
        for (int i = 0; i < 400; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            wa = 5'($urandom_range(0, 7));
            a1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom);
            a2 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 7));
            cycle(1'b1, en, wa, $urandom, a1, a2);
        end

        // Reset mid-RUN
        cycle(1'b1, 1'b1, 5'd9, 32'h00001234, 5'd0, 5'd0);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd9, 5'd9);
        idle(34);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd9, 5'd5);

        // Reset mid-CLEAR restarts the sequence
        cycle(1'b1, 1'b1, 5'd4, 32'hCAFEF00D, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 32'd0, 5'd4, 5'd4);
        idle(5);
        cycle(1'b0, 1'b1, 5'd6, 32'h5A5A5A5A, 5'd6, 5'd4);
        idle(34);
        cycle(1'b1, 1'b0, 5'd0, 32'd0, 5'd4, 5'd6);
        for (int i = 0; i < 40; i++)
            cycle(1'b1, 1'b1, 5'($urandom), $urandom, 5'($urandom), 5'($urandom));

        @(negedge clk);
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
